// File: rtl/mult_pkg.sv
// Shared multiplier definitions: operand/result width, pipeline depth and the result word type.
package mult_pkg;

  localparam int MULT_W = 64;
  localparam int STAGES = 4;

  typedef logic [MULT_W-1:0] mult_word_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_result_queue_if.sv
// Handshake bundle between the multiplier/consumer side and the result queue.
interface mult_result_queue_if #(
  parameter int DEPTH = 8
);
  import mult_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic             issue;
  logic             mult_done;
  mult_word_t       mult_product;
  logic             can_issue;
  logic             out_valid;
  logic             out_ready;
  mult_word_t       out_product;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] inflight;
  logic             err;

  modport slave (
    input  issue, mult_done, mult_product, out_ready,
    output can_issue, out_valid, out_product, occupancy, inflight, err
  );

  modport master (
    output issue, mult_done, mult_product, out_ready,
    input  can_issue, out_valid, out_product, occupancy, inflight, err
  );

endinterface

// File: rtl/mult_fifo_mem.sv
// DEPTH x 64 result storage: one synchronous write port, one asynchronous read port.
module mult_fifo_mem
  import mult_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  mult_word_t       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output mult_word_t       rd_data
);

  mult_word_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mult_result_queue.sv
// Credit-tracked result FIFO behind the pipelined multiplier.
// Optional zero-latency pass-through when empty: define MULT_RESULT_BYPASS_EN.
module mult_result_queue
  import mult_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  mult_result_queue_if.slave  q
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   LIMIT = (CNT_W+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("mult_result_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] inflight;
  logic             err;

  logic             stored_valid;
  logic             deq;
  logic             bypass;
  logic             enq_req;
  logic             wr_en;
  logic             err_set;
  logic [CNT_W:0]   credit_sum;
  mult_word_t       rd_data;

  mult_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (tail),
    .wr_data (q.mult_product),
    .rd_addr (head),
    .rd_data (rd_data)
  );

  // A full queue still accepts a result when the head leaves in the same cycle.
  always_comb begin
    stored_valid = (occupancy != '0);
    deq          = stored_valid && q.out_ready;
`ifdef MULT_RESULT_BYPASS_EN
    bypass       = !stored_valid && q.mult_done && q.out_ready;
`else
    bypass       = 1'b0;
`endif
    enq_req      = q.mult_done && !bypass;
    wr_en        = enq_req && ((occupancy != FULL) || deq);
    credit_sum   = {1'b0, occupancy} + {1'b0, inflight};
    err_set      = (q.issue && !q.can_issue)
                || (q.mult_done && (inflight == '0) && !q.issue)
                || (q.mult_done && (occupancy == FULL) && !deq);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) begin
        tail <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({wr_en, deq})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // In-flight count saturates at both ends so protocol errors cannot wrap it.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else if (q.issue && !q.mult_done) begin
      if (inflight != FULL) begin
        inflight <= inflight + 1'b1;
      end
    end else if (!q.issue && q.mult_done) begin
      if (inflight != '0) begin
        inflight <= inflight - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign q.can_issue   = (credit_sum < LIMIT);
  assign q.out_valid   = stored_valid || bypass;
  assign q.out_product = bypass ? q.mult_product : (stored_valid ? rd_data : '0);
  assign q.occupancy   = occupancy;
  assign q.inflight    = inflight;
  assign q.err         = err;

endmodule

// File: doc/mult_result_queue.md
Name: mult_result_queue

Overview:
- Downstream consumer of the pipelined 64-bit multiplier.
- Captures each `product` on the multiplier's `done` pulse into a FIFO and presents results to a consumer over a valid/ready handshake.
- The multiplier cannot stall, so the block also issues credits upstream. A `start` is allowed only when a FIFO slot is guaranteed for its result.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and in-flight counters (derived; not overridden).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- issue  input  1  high in the cycle the multiplier's `start` is asserted; counted as a new in-flight op
- mult_done  input  1  multiplier `done`
- mult_product  input  64  multiplier `product`, valid when `mult_done`
- can_issue  output  1  credit available; upstream asserts `issue` only when this is high
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_product  output  64  head product
- occupancy  output  CNT_W  entries currently stored
- inflight  output  CNT_W  issued ops not yet returned
- err  output  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous and active-high, sampled on posedge `clock`.
- Reset values: occupancy=0, inflight=0, head/tail=0, out_valid=0, out_product=0, err=0, can_issue=1.
- Reset mid-operation discards all stored and in-flight results. The multiplier is reset by the same signal, so no stale `done` can follow.
- Storage:
  - Circular buffer with head/tail pointers of width $clog2(DEPTH).
  - Pointers wrap modulo DEPTH.
- Enqueue: when `mult_done`=1, write `mult_product` at tail; tail+1, occupancy+1.
- Dequeue: when out_valid && out_ready; head+1, occupancy-1.
- Output path:
  - out_valid = (occupancy != 0).
  - out_product = mem[head], read combinationally; a registered read is not permitted.
  - Minimum latency from `mult_done` to out_valid is one cycle.
- Simultaneous enqueue and dequeue:
  - Both happen; occupancy is unchanged.
  - This is legal when full, because the head entry frees in the same cycle.
  - When empty with simultaneous enqueue, only the enqueue occurs; the dequeue cannot fire since out_valid=0.
- inflight counter:
  - +1 on `issue`, -1 on `mult_done`.
  - Both in the same cycle leaves it unchanged.
- Credit:
  - can_issue = (occupancy + inflight) < DEPTH, computed combinationally from registered counters.
  - A dequeue in the current cycle does not raise can_issue until the next cycle.
- Error conditions: err is set and held until reset on any of:
  - `issue` while can_issue=0;
  - `mult_done` with inflight=0 and no same-cycle `issue`;
  - `mult_done` with occupancy=DEPTH and no same-cycle dequeue.
- Error handling:
  - On an overflowing enqueue the write is dropped and counters saturate.
  - On an `issue` without credit, inflight still increments, saturating at DEPTH.
- No internal state machine beyond counters and pointers. The block is a credit-tracked FIFO.

Optional Feature:
- Macro: MULT_RESULT_BYPASS_EN.
- When defined:
  - If occupancy=0 && mult_done && out_ready: the result passes combinationally. out_valid=1, out_product=mult_product, nothing is written, and counters only reflect the inflight decrement.
  - If occupancy=0 && mult_done && !out_ready: the result is enqueued normally.
  - Effective latency 0 cycles when empty.
- When not defined: all results go through storage, with 1-cycle minimum latency as above.

Decomposition:
- Shared package mult_pkg:
  - MULT_W=64;
  - typedef logic [63:0] mult_word_t;
  - the existing STAGES constant, for benches that compute expected latency.
- Natural sub-module: mult_fifo_mem, a DEPTH x 64 register array with one write port and one asynchronous read port. Pointers, counters, credit and error logic stay in mult_result_queue.

Test Plan:
- Reset, then issue 3 ops (mcand/mplier 3x5, 7x9, 0xFFFF_FFFF x 2) through the real mult with out_ready=1 -> out_product 15, 63, 0x1_FFFF_FFFE in order; occupancy returns to 0; err=0.
- out_ready=0, issue while can_issue -> exactly 8 issues accepted; can_issue falls after the 8th issue. After all dones: occupancy=8, inflight=0. Drain -> 8 products in issue order.
- Full queue with out_ready=1 and a held upstream issue stream -> one dequeue per cycle; can_issue re-rises one cycle after each dequeue; steady-state throughput 1/cycle with no drops.
- Force `issue` when can_issue=0 -> err=1 the next cycle and stays 1. Reset -> err=0, occupancy=0, inflight=0.
- Assert reset while 4 ops are in flight and 2 are stored -> next cycle out_valid=0, can_issue=1; no spurious out_valid afterwards.
- Build with MULT_RESULT_BYPASS_EN, queue empty, out_ready=1, product 42 on mult_done -> out_valid=1 and out_product=42 in the same cycle; occupancy stays 0.
